instruction_fetch_stage: RTL and testbench

- Upstream neighbour of the LEGv8 ControlUnit.
- Holds the program counter and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Captures each returned instruction into an IF/ID register and presents opcode = instr[31:21] to ControlUnit.OpCode.
- Honours decode-stage stalls and branch redirects from EX (Branch & Zero).

---
 rtl/instruction_fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - LEGv8 fetch stage: PC, imem req/gnt/rvalid, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch/stall/kill counters.
module instruction_fetch_stage #(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              if_id_valid,
   output logic [31:0]       if_id_instr,
   output logic [ADDR_W-1:0] if_id_pc,
   output logic [10:0]       opcode
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       stall_cnt,
   output logic [15:0]       kill_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } stateT;

   stateT             state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] reqPc;
   logic              kill;
   logic              bufValid;
   logic [31:0]       bufInstr;
   logic [ADDR_W-1:0] bufPc;

   logic loadNew;
   logic loadBuf;
   logic toBuf;
   logic discard;

   assign loadNew = (state == WAIT) && imem_rvalid && !kill && !branch_taken
                    && (!stall || !if_id_valid);
   assign toBuf   = (state == WAIT) && imem_rvalid && !kill && !branch_taken
                    && stall && if_id_valid;
   assign loadBuf = (state == HOLD) && bufValid && !stall && !branch_taken;
   assign discard = (state == WAIT) && imem_rvalid && (kill || branch_taken);

   assign imem_addr = pc;
   assign opcode    = if_id_valid ? if_id_instr[31:21] : 11'h0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         reqPc       <= '0;
         kill        <= 1'b0;
         imem_req    <= 1'b0;
         if_id_valid <= 1'b0;
         if_id_instr <= '0;
         if_id_pc    <= '0;
         bufValid    <= 1'b0;
         bufInstr    <= '0;
         bufPc       <= '0;
      end else begin
         // ID consuming the current entry leaves a bubble unless something new arrives
         if (!stall) begin
            if_id_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               state    <= REQ;
               imem_req <= 1'b1;
            end
            REQ: begin
               if (imem_gnt) begin
                  reqPc    <= pc;
                  state    <= WAIT;
                  imem_req <= 1'b0;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (kill) begin
                     kill     <= 1'b0;
                     state    <= REQ;
                     imem_req <= 1'b1;
                  end else begin
                     pc <= reqPc + ADDR_W'(4);
                     if (toBuf) begin
                        bufValid <= 1'b1;
                        bufInstr <= imem_rdata;
                        bufPc    <= reqPc;
                        state    <= HOLD;
                        imem_req <= 1'b0;
                     end else begin
                        if_id_valid <= 1'b1;
                        if_id_instr <= imem_rdata;
                        if_id_pc    <= reqPc;
                        state       <= REQ;
                        imem_req    <= 1'b1;
                     end
                  end
               end
            end
            HOLD: begin
               if (loadBuf) begin
                  if_id_valid <= 1'b1;
                  if_id_instr <= bufInstr;
                  if_id_pc    <= bufPc;
                  bufValid    <= 1'b0;
                  state       <= REQ;
                  imem_req    <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase

         // Redirect overrides everything above, including a stall
         if (branch_taken) begin
            pc          <= branch_target & ~ADDR_W'(3);
            if_id_valid <= 1'b0;
            bufValid    <= 1'b0;
            case (state)
               REQ: begin
                  if (imem_gnt) begin
                     kill <= 1'b1;
                  end
               end
               WAIT: begin
                  if (imem_rvalid) begin
                     kill     <= 1'b0;
                     state    <= REQ;
                     imem_req <= 1'b1;
                  end else begin
                     kill <= 1'b1;
                  end
               end
               HOLD: begin
                  state    <= REQ;
                  imem_req <= 1'b1;
               end
               default: begin
               end
            endcase
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
         kill_cnt  <= '0;
      end else begin
         if (loadNew || loadBuf) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (stall && if_id_valid) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (discard) begin
            kill_cnt <= kill_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed bench for instruction_fetch_stage.
// Define FETCH_PERF_CNT_EN to also exercise the performance counters.
module tb_instruction_fetch_stage;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [63:0] if_id_pc;
   logic [10:0] opcode;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
   logic [15:0] kill_cnt;
`endif

   int tests;
   int fails;

   logic        gntEn;
   logic        rvEn;
   logic        pending;
   logic [63:0] pendAddr;

   instruction_fetch_stage #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .if_id_valid  (if_id_valid),
      .if_id_instr  (if_id_instr),
      .if_id_pc     (if_id_pc),
      .opcode       (opcode)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt    (fetch_cnt),
      .stall_cnt    (stall_cnt),
      .kill_cnt     (kill_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memData(input logic [63:0] a);
      return 32'h8B020020 ^ a[31:0];
   endfunction

   // Instruction memory: grant in the request cycle, data one cycle later
   always @(negedge clk) begin
      if (rst) begin
         pending     = 1'b0;
         imem_gnt    = 1'b0;
         imem_rvalid = 1'b0;
      end else begin
         imem_rvalid = pending && rvEn;
         if (imem_rvalid) begin
            imem_rdata = memData(pendAddr);
            pending    = 1'b0;
         end
         imem_gnt = imem_req && gntEn && !pending;
         if (imem_gnt) begin
            pending  = 1'b1;
            pendAddr = imem_addr;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
      tests++; if (if_id_instr !== 32'h0) begin fails++; $display("FAIL reset_instr got=%h exp=0", if_id_instr); end
      tests++; if (if_id_pc !== 64'h0) begin fails++; $display("FAIL reset_pc got=%h exp=0", if_id_pc); end
      tests++; if (opcode !== 11'h0) begin fails++; $display("FAIL reset_opcode got=%h exp=0", opcode); end
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      logic [63:0] a;
      step();
      tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin fails++; $display("FAIL seq_first_req req=%b addr=%h exp 1/0", imem_req, imem_addr); end
      for (int k = 0; k < 3; k++) begin
         a = 64'(4 * k);
         step();
         tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL seq_wait_req k=%0d got=%b exp=0", k, imem_req); end
         step();
         tests++; if (if_id_valid !== 1'b1 || if_id_pc !== a) begin fails++; $display("FAIL seq_ifid k=%0d valid=%b pc=%h exp 1/%h", k, if_id_valid, if_id_pc, a); end
         tests++; if (if_id_instr !== (32'h8B020020 | 32'(a))) begin fails++; $display("FAIL seq_instr k=%0d got=%h", k, if_id_instr); end
         tests++; if (imem_req !== 1'b1 || imem_addr !== a + 64'd4) begin fails++; $display("FAIL seq_next_addr k=%0d req=%b addr=%h exp %h", k, imem_req, imem_addr, a + 64'd4); end
         if (k == 0) begin
            tests++; if (opcode !== 11'h458) begin fails++; $display("FAIL seq_opcode got=%h exp=458", opcode); end
         end
      end
   endtask

   task automatic test_stall_hold();
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h8 || if_id_instr !== 32'h8B020028) begin
            fails++; $display("FAIL hold_ifid c=%0d valid=%b pc=%h instr=%h", c, if_id_valid, if_id_pc, if_id_instr); end
         if (c > 0) begin
            tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL hold_req c=%0d got=%b exp=0", c, imem_req); end
         end
      end
      stall = 1'b0;
      step();
      tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'hC || if_id_instr !== 32'h8B02002C) begin
         fails++; $display("FAIL hold_release valid=%b pc=%h instr=%h exp 1/c/8b02002c", if_id_valid, if_id_pc, if_id_instr); end
      tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h10) begin fails++; $display("FAIL hold_resume req=%b addr=%h exp 1/10", imem_req, imem_addr); end
      step();
      step();
      tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h10) begin fails++; $display("FAIL hold_next valid=%b pc=%h exp 1/10", if_id_valid, if_id_pc); end
   endtask

   task automatic test_branch_wait();
      rvEn = 1'b0;
      step();
      branch_taken  = 1'b1;
      branch_target = 64'h103;
      step();
      branch_taken = 1'b0;
      rvEn = 1'b1;
      tests++; if (if_id_valid !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL bw_after valid=%b req=%b exp 0/0", if_id_valid, imem_req); end
      step();
      tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL bw_discard valid=%b pc=%h exp valid 0", if_id_valid, if_id_pc); end
      tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin fails++; $display("FAIL bw_target req=%b addr=%h exp 1/100", imem_req, imem_addr); end
      step();
      step();
      tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h100 || if_id_instr !== 32'h8B020120) begin
         fails++; $display("FAIL bw_deliver valid=%b pc=%h instr=%h exp 1/100/8b020120", if_id_valid, if_id_pc, if_id_instr); end
   endtask

   task automatic test_branch_stall();
      stall         = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 64'h200;
      step();
      branch_taken = 1'b0;
      stall        = 1'b0;
      tests++; if (if_id_valid !== 1'b0 || opcode !== 11'h0) begin fails++; $display("FAIL bs_flush valid=%b opcode=%h exp 0/0", if_id_valid, opcode); end
      step();
      tests++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h200) begin
         fails++; $display("FAIL bs_kill valid=%b req=%b addr=%h exp 0/1/200", if_id_valid, imem_req, imem_addr); end
      step();
      step();
      tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h200 || if_id_instr !== 32'h8B020220) begin
         fails++; $display("FAIL bs_deliver valid=%b pc=%h instr=%h", if_id_valid, if_id_pc, if_id_instr); end
   endtask

   task automatic test_back_to_back();
      gntEn         = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 64'h300;
      step();
      branch_target = 64'h400;
      step();
      branch_taken = 1'b0;
      gntEn        = 1'b1;
      tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h400) begin fails++; $display("FAIL b2b_addr req=%b addr=%h exp 1/400", imem_req, imem_addr); end
      step();
      step();
      tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h400) begin fails++; $display("FAIL b2b_deliver valid=%b pc=%h exp 1/400", if_id_valid, if_id_pc); end
   endtask

   task automatic test_wrap();
      gntEn         = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      branch_taken = 1'b0;
      gntEn        = 1'b1;
      tests++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL wrap_top addr=%h exp fffffffffffffffc", imem_addr); end
      step();
      step();
      tests++; if (if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_id_instr !== 32'h74FDFFDC) begin
         fails++; $display("FAIL wrap_deliver pc=%h instr=%h exp fffffffffffffffc/74fdffdc", if_id_pc, if_id_instr); end
      tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin fails++; $display("FAIL wrap_zero req=%b addr=%h exp 1/0", imem_req, imem_addr); end
   endtask

   task automatic test_stall_empty();
      step();
      tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL se_bubble valid=%b exp 0", if_id_valid); end
      stall = 1'b1;
      step();
      tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0) begin fails++; $display("FAIL se_load valid=%b pc=%h exp 1/0", if_id_valid, if_id_pc); end
      stall = 1'b0;
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_perf();
      rst = 1'b1;
      repeat (2) step();
      tests++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0 || kill_cnt !== 16'd0) begin
         fails++; $display("FAIL perf_reset f=%0d s=%0d k=%0d exp 0/0/0", fetch_cnt, stall_cnt, kill_cnt); end
      rst = 1'b0;
      step();
      repeat (6) step();
      stall = 1'b1;
      repeat (2) step();
      stall = 1'b0;
      step();
      branch_taken  = 1'b1;
      branch_target = 64'h40;
      step();
      branch_taken = 1'b0;
      repeat (3) step();
      tests++; if (if_id_pc !== 64'h40 || if_id_valid !== 1'b1) begin fails++; $display("FAIL perf_pc pc=%h valid=%b exp 40/1", if_id_pc, if_id_valid); end
      tests++; if (fetch_cnt !== 32'd5 || stall_cnt !== 32'd2 || kill_cnt !== 16'd1) begin
         fails++; $display("FAIL perf_counts f=%0d s=%0d k=%0d exp 5/2/1", fetch_cnt, stall_cnt, kill_cnt); end
      step();
      rst = 1'b1;
      #1;
      tests++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0 || kill_cnt !== 16'd0) begin
         fails++; $display("FAIL perf_midwait_reset f=%0d s=%0d k=%0d exp 0/0/0", fetch_cnt, stall_cnt, kill_cnt); end
      step();
      rst = 1'b0;
   endtask
`endif

   initial begin
      tests         = 0;
      fails         = 0;
      rst           = 1'b1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 64'h0;
      imem_gnt      = 1'b0;
      imem_rvalid   = 1'b0;
      imem_rdata    = 32'h0;
      gntEn         = 1'b1;
      rvEn          = 1'b1;
      pending       = 1'b0;
      pendAddr      = 64'h0;
      #2;
      test_reset();
      test_sequential();
      test_stall_hold();
      test_branch_wait();
      test_branch_stall();
      test_back_to_back();
      test_wrap();
      test_stall_empty();
`ifdef FETCH_PERF_CNT_EN
      test_perf();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
